// File: rtl/jt1942_rom_arb.sv
// Five-slot ROM read arbiter in front of a single SDRAM read port.
// Each slot caches one fetched byte/word; misses are served round-robin.
module jt1942_rom_arb #(
    parameter int          MAIN_AW     = 17,
    parameter int          SND_AW      = 15,
    parameter int          CHAR_AW     = 12,
    parameter int          SCR_AW      = 14,
    parameter int          OBJ_AW      = 15,
    parameter logic [21:0] SND_OFFSET  = 22'h1_0000,
    parameter logic [21:0] CHAR_OFFSET = 22'h1_4000,
    parameter logic [21:0] SCR_OFFSET  = 22'h1_5000,
    parameter logic [21:0] OBJ_OFFSET  = 22'h1_9000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               downloading,

    input  logic               main_cs,
    input  logic [MAIN_AW-1:0] main_addr,
    output logic [7:0]         main_data,
    output logic               main_ok,

    input  logic               snd_cs,
    input  logic [SND_AW-1:0]  snd_addr,
    output logic [7:0]         snd_data,
    output logic               snd_ok,

    input  logic               char_cs,
    input  logic [CHAR_AW-1:0] char_addr,
    output logic [15:0]        char_data,
    output logic               char_ok,

    input  logic               scr_cs,
    input  logic [SCR_AW-1:0]  scr_addr,
    output logic [15:0]        scr_data,
    output logic               scr_ok,

    input  logic               obj_cs,
    input  logic [OBJ_AW-1:0]  obj_addr,
    output logic [15:0]        obj_data,
    output logic               obj_ok,

    output logic               sdram_req,
    output logic [21:0]        sdram_addr,
    input  logic               sdram_ack,
    input  logic               data_rdy,
    input  logic [15:0]        data_read
);

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    localparam int AW = max2(max2(max2(MAIN_AW, SND_AW), max2(CHAR_AW, SCR_AW)), OBJ_AW);

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT} state_t;

    state_t        state;
    logic [2:0]    ptr;
    logic [2:0]    sel;
    logic [AW-1:0] lat_addr;
    logic [4:0]    valid;
    logic [AW-1:0] caddr [5];

    logic [4:0]    cs;
    logic [4:0]    hit;
    logic [4:0]    pend;
    logic [AW-1:0] raw [5];
    logic [21:0]   map [5];
    logic [2:0]    pick;
    logic          found;
    logic [7:0]    byte_sel;

    always_comb begin
        cs     = {obj_cs, scr_cs, char_cs, snd_cs, main_cs};
        raw[0] = AW'(main_addr);
        raw[1] = AW'(snd_addr);
        raw[2] = AW'(char_addr);
        raw[3] = AW'(scr_addr);
        raw[4] = AW'(obj_addr);
        // byte slots drop addr[0]; it picks the half of the word later
        map[0] = 22'(main_addr[MAIN_AW-1:1]);
        map[1] = SND_OFFSET  + 22'(snd_addr[SND_AW-1:1]);
        map[2] = CHAR_OFFSET + 22'(char_addr);
        map[3] = SCR_OFFSET  + 22'(scr_addr);
        map[4] = OBJ_OFFSET  + 22'(obj_addr);
        for (int i = 0; i < 5; i++) begin
            hit[i]  = cs[i] & valid[i] & (raw[i] == caddr[i]);
            pend[i] = cs[i] & ~(valid[i] & (raw[i] == caddr[i]));
        end
        pick  = ptr;
        found = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (!found && pend[(int'(ptr) + k) % 5]) begin
                found = 1'b1;
                pick  = 3'((int'(ptr) + k) % 5);
            end
        end
        byte_sel = lat_addr[0] ? data_read[15:8] : data_read[7:0];
    end

    assign main_ok = hit[0];
    assign snd_ok  = hit[1];
    assign char_ok = hit[2];
    assign scr_ok  = hit[3];
    assign obj_ok  = hit[4];

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            ptr        <= 3'd0;
            sel        <= 3'd0;
            lat_addr   <= '0;
            valid      <= '0;
            sdram_req  <= 1'b0;
            sdram_addr <= '0;
            main_data  <= '0;
            snd_data   <= '0;
            char_data  <= '0;
            scr_data   <= '0;
            obj_data   <= '0;
            for (int i = 0; i < 5; i++) caddr[i] <= '0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (!downloading && found) begin
                        sel        <= pick;
                        lat_addr   <= raw[pick];
                        sdram_addr <= map[pick];
                        sdram_req  <= 1'b1;
                        state      <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (sdram_ack) begin
                        sdram_req <= 1'b0;
                        state     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (data_rdy) begin
                        // a fetch that straddles a download is dropped
                        if (!downloading) begin
                            unique case (sel)
                                3'd0:    main_data <= byte_sel;
                                3'd1:    snd_data  <= byte_sel;
                                3'd2:    char_data <= data_read;
                                3'd3:    scr_data  <= data_read;
                                default: obj_data  <= data_read;
                            endcase
                            caddr[sel] <= lat_addr;
                            valid[sel] <= 1'b1;
                        end
                        ptr   <= (sel == 3'd4) ? 3'd0 : sel + 3'd1;
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
            if (downloading) valid <= '0;
        end
    end

endmodule

// File: tb/tb_jt1942_rom_arb.sv
// Directed-vector bench for jt1942_rom_arb with a minimal SDRAM responder.
// Expected addresses and data are hand-computed constants.
module tb_jt1942_rom_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        downloading;
    logic        main_cs, snd_cs, char_cs, scr_cs, obj_cs;
    logic [16:0] main_addr;
    logic [14:0] snd_addr;
    logic [11:0] char_addr;
    logic [13:0] scr_addr;
    logic [14:0] obj_addr;
    logic [7:0]  main_data, snd_data;
    logic [15:0] char_data, scr_data, obj_data;
    logic        main_ok, snd_ok, char_ok, scr_ok, obj_ok;
    logic        sdram_req;
    logic [21:0] sdram_addr;
    logic        sdram_ack, data_rdy;
    logic [15:0] data_read;

    int n_chk = 0;
    int n_pass = 0;

    jt1942_rom_arb dut (
        .clk(clk), .rst(rst), .downloading(downloading),
        .main_cs(main_cs), .main_addr(main_addr),
        .main_data(main_data), .main_ok(main_ok),
        .snd_cs(snd_cs), .snd_addr(snd_addr),
        .snd_data(snd_data), .snd_ok(snd_ok),
        .char_cs(char_cs), .char_addr(char_addr),
        .char_data(char_data), .char_ok(char_ok),
        .scr_cs(scr_cs), .scr_addr(scr_addr),
        .scr_data(scr_data), .scr_ok(scr_ok),
        .obj_cs(obj_cs), .obj_addr(obj_addr),
        .obj_data(obj_data), .obj_ok(obj_ok),
        .sdram_req(sdram_req), .sdram_addr(sdram_addr),
        .sdram_ack(sdram_ack), .data_rdy(data_rdy),
        .data_read(data_read)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_req(input string tag, input logic [21:0] exp);
        int n;
        n = 0;
        while (!sdram_req && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_req"}, 32'(sdram_req), 32'd1);
        chk({tag, "_addr"}, 32'(sdram_addr), 32'(exp));
    endtask

    task automatic do_ack();
        sdram_ack = 1'b1;
        tick();
        sdram_ack = 1'b0;
    endtask

    task automatic do_rdy(input logic [15:0] d);
        data_read = d;
        data_rdy  = 1'b1;
        tick();
        data_rdy  = 1'b0;
    endtask

    task automatic serve(input string tag, input logic [21:0] exp,
                         input logic [15:0] d);
        wait_req(tag, exp);
        tick();
        do_ack();
        tick();
        do_rdy(d);
    endtask

    task automatic clear_cs();
        main_cs = 0; snd_cs = 0; char_cs = 0; scr_cs = 0; obj_cs = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; downloading = 1'b0;
        clear_cs();
        main_addr = '0; snd_addr = '0; char_addr = '0;
        scr_addr = '0; obj_addr = '0;
        sdram_ack = 1'b0; data_rdy = 1'b0; data_read = '0;
        do_reset();

        chk("rst_req", 32'(sdram_req), 32'd0);
        chk("rst_addr", 32'(sdram_addr), 32'd0);
        chk("rst_ok", 32'({main_ok, snd_ok, char_ok, scr_ok, obj_ok}), 32'd0);
        chk("rst_data", 32'({main_data, snd_data} | char_data | scr_data | obj_data), 32'd0);

        // single miss on char
        char_cs = 1; char_addr = 12'h005;
        tick();
        chk("char_req", 32'(sdram_req), 32'd1);
        chk("char_addr", 32'(sdram_addr), 32'h1_4005);
        tick();
        tick();
        chk("char_hold", 32'({sdram_req, sdram_addr}), 32'({1'b1, 22'h1_4005}));
        do_ack();
        chk("char_ackdrop", 32'(sdram_req), 32'd0);
        tick();
        tick();
        do_rdy(16'hBEEF);
        chk("char_data", 32'(char_data), 32'hBEEF);
        chk("char_ok", 32'(char_ok), 32'd1);
        tick(); tick(); tick();
        chk("char_noreq", 32'(sdram_req), 32'd0);
        char_cs = 0;

        // byte select on main
        main_cs = 1; main_addr = 17'h00003;
        serve("main_hi", 22'h1, 16'h1234);
        chk("main_hi_data", 32'(main_data), 32'h12);
        chk("main_hi_ok", 32'(main_ok), 32'd1);
        main_addr = 17'h00002;
        #1;
        chk("main_lo_miss", 32'(main_ok), 32'd0);
        serve("main_lo", 22'h1, 16'h1234);
        chk("main_lo_data", 32'(main_data), 32'h34);
        chk("main_lo_ok", 32'(main_ok), 32'd1);
        main_cs = 0;

        // round robin from pointer = main
        do_reset();
        main_cs = 1; main_addr = 17'h10;
        snd_cs  = 1; snd_addr  = 15'h20;
        obj_cs  = 1; obj_addr  = 15'h30;
        serve("rr_main", 22'h8, 16'hA1A2);
        chk("rr_main_data", 32'(main_data), 32'hA2);
        main_addr = 17'h12;
        serve("rr_snd", 22'h1_0010, 16'hB1B2);
        chk("rr_snd_data", 32'(snd_data), 32'hB2);
        serve("rr_obj", 22'h1_9030, 16'hC0DE);
        chk("rr_obj_ok", 32'(obj_ok), 32'd1);
        chk("rr_main_pend", 32'(main_ok), 32'd0);
        serve("rr_main2", 22'h9, 16'hD1D2);
        chk("rr_main2_data", 32'(main_data), 32'hD2);
        chk("rr_all_ok", 32'({main_ok, snd_ok, obj_ok}), 32'h7);
        clear_cs();

        // scroll address moves during WAIT
        scr_cs = 1; scr_addr = 14'h10;
        wait_req("scr1", 22'h1_5010);
        do_ack();
        scr_addr = 14'h11;
        tick();
        do_rdy(16'h5A5A);
        chk("scr_stale_ok", 32'(scr_ok), 32'd0);
        serve("scr2", 22'h1_5011, 16'h6B6B);
        chk("scr2_ok", 32'(scr_ok), 32'd1);
        chk("scr2_data", 32'(scr_data), 32'h6B6B);
        scr_cs = 0;

        // download blocks and flushes
        main_cs = 1; main_addr = 17'h40;
        serve("dl_pre", 22'h20, 16'h0077);
        chk("dl_pre_ok", 32'(main_ok), 32'd1);
        downloading = 1;
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("dl_ok", 32'(main_ok), 32'd0);
            chk("dl_req", 32'(sdram_req), 32'd0);
        end
        downloading = 0;
        serve("dl_post", 22'h20, 16'h0088);
        chk("dl_post_ok", 32'(main_ok), 32'd1);
        chk("dl_post_data", 32'(main_data), 32'h88);
        main_cs = 0;

        // reset while waiting for data
        snd_cs = 1; snd_addr = 15'h5;
        wait_req("rw", 22'h1_0002);
        do_ack();
        clear_cs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rw_req", 32'(sdram_req), 32'd0);
        chk("rw_data", 32'({main_data, snd_data} | char_data | scr_data | obj_data), 32'd0);
        tick();
        do_rdy(16'hFFFF);
        tick();
        chk("rw_stray_data", 32'({main_data, snd_data} | char_data | scr_data | obj_data), 32'd0);
        chk("rw_stray_req", 32'(sdram_req), 32'd0);
        snd_cs = 1;
        #1;
        chk("rw_stray_ok", 32'(snd_ok), 32'd0);
        snd_cs = 0;

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/jt1942_rom_arb.md
Name: jt1942_rom_arb

Overview:
- Read arbiter between the game's five ROM slots (main, snd, char, scr, obj) and the single SDRAM read port.
- Each slot keeps a one-entry cache: last address, data and a valid flag.
- The arbiter serves slots whose requested address misses, one SDRAM transaction at a time, round-robin.
- Sits directly downstream of the game top's `*_cs`/`*_addr`/`*_data`/`*_ok` ROM ports, and upstream of the SDRAM controller.

Parameters:
- MAIN_AW, 17, main byte-address width
- SND_AW, 15, sound byte-address width
- CHAR_AW, 12, char word-address width
- SCR_AW, 14, scroll word-address width
- OBJ_AW, 15, object word-address width
- SND_OFFSET, 22'h1_0000, SDRAM word offset of sound ROM
- CHAR_OFFSET, 22'h1_4000, SDRAM word offset of char ROM
- SCR_OFFSET, 22'h1_5000, SDRAM word offset of scroll ROM
- OBJ_OFFSET, 22'h1_9000, SDRAM word offset of object ROM
- Main ROM offset is fixed at 0.

Ports:
- clk  in  1  system clock; all logic on rising edge
- rst  in  1  synchronous reset, active-high
- downloading  in  1  ROM download in progress; blocks reads
- main_cs  in  1  main slot request
- main_addr  in  MAIN_AW  main byte address
- main_data  out  8  main byte
- main_ok  out  1  main_data valid for main_addr
- snd_cs, snd_addr[SND_AW], snd_data[8], snd_ok  as main, sound slot
- char_cs, char_addr[CHAR_AW], char_data[16], char_ok  word slot
- scr_cs, scr_addr[SCR_AW], scr_data[16], scr_ok  word slot
- obj_cs, obj_addr[OBJ_AW], obj_data[16], obj_ok  word slot
- sdram_req  out  1  read request, held until acknowledged
- sdram_addr  out  22  SDRAM word address
- sdram_ack  in  1  request accepted (one-cycle pulse)
- data_rdy  in  1  read data valid (one-cycle pulse)
- data_read  in  16  SDRAM read data

Behaviour:
- Reset values:
  - all *_data = 0; all valid flags = 0, so all *_ok = 0.
  - sdram_req = 0, sdram_addr = 0, FSM = IDLE, round-robin pointer = main.
- Address mapping:
  - Byte slots: word address = offset + addr[AW-1:1]; addr[0]=0 selects data_read[7:0], addr[0]=1 selects [15:8].
  - Word slots: word address = offset + addr, zero-extended to 22 bits; addition wraps modulo 2^22.
- Hit and ok:
  - *_ok = cs & valid & (addr == stored addr). Combinational from registered state.
  - *_data is registered and holds the last fetched value regardless of cs.
- Miss: cs & ~(valid & addr match) marks the slot pending. Pending is evaluated each cycle.
- FSM:
  - IDLE: if ~downloading and any slot is pending, pick the first pending slot in round-robin order, starting after the last slot served. Latch its slot id, mapped address and raw slot address. Set sdram_req=1, sdram_addr=mapped. Go to REQ next cycle.
  - REQ: hold sdram_req and sdram_addr stable until sdram_ack. On the ack cycle, sdram_req=0 and go to WAIT.
  - WAIT: on data_rdy, write the selected byte/word into the slot's data register, store the latched raw address, set valid=1, advance the pointer past that slot, and go to IDLE.
- Timing: ok rises the cycle after data_rdy (if cs and address still match). Minimum miss-to-ok latency is IDLE(1) + REQ(≥1) + WAIT(≥1) + 1.
- No back-to-back overlap: at most one transaction is outstanding; IDLE always costs one cycle.
- Address changes mid-fetch: the result is still cached against the latched address, so ok stays low; the slot becomes pending again and is re-requested in a later turn.
- cs dropped mid-fetch: the transaction completes and is cached; ok stays low while cs=0.
- Simultaneous misses: served strictly round-robin. Each slot waits at most 4 transactions.
- downloading=1:
  - Clears all valid flags every cycle and blocks new grants from IDLE.
  - An in-flight REQ/WAIT completes its handshake, but its data is discarded (valid not set).
  - sdram_req is never raised from IDLE while downloading=1.
- data_rdy outside WAIT and sdram_ack outside REQ are ignored.
- Reset mid-transaction: FSM returns to IDLE and sdram_req drops in the same cycle reset is sampled. A later stray data_rdy is ignored.

Test Plan:
- Single miss: char_cs=1, char_addr=12'h005 from reset.
  - Required: sdram_req=1 with sdram_addr=22'h1_4005 one cycle later.
  - Ack after 2 cycles, data_rdy with 16'hBEEF after 3 more: char_data=16'hBEEF and char_ok=1 the next cycle, no further request.
- Byte select: main_addr=17'h00003.
  - Required: sdram_addr=22'h1; data_read=16'h12_34 gives main_data=8'h12.
  - Then main_addr=17'h00002: new request to 22'h1, main_data=8'h34.
- Round-robin: main, snd, obj all missing at once, pointer at main.
  - Required grant order main, snd, obj.
  - If main re-misses immediately after, obj is served before main's second request.
- Address change mid-fetch: scr_addr changes 14'h10 -> 14'h11 during WAIT.
  - Required: scr_ok stays 0; second request issued to 22'h1_5011; scr_ok=1 only after it returns.
- Download: valid main hit, then downloading=1 for 10 cycles.
  - Required: main_ok=0 throughout; sdram_req stays 0; after release a fresh request is issued.
- Reset during WAIT.
  - Required: sdram_req=0, all ok=0, all data=0; a data_rdy pulse 2 cycles later leaves all outputs unchanged.
